// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: program ROM read port plus the issue handshake to the control unit.
// The master side is the fetch unit; the slave side is the ROM/control-unit pairing.
interface instr_fetch_unit_if #(
  parameter int AW = 8
);
  localparam int IW = AW + 5;

  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [IW-1:0] rom_data;
  logic [4:0]    opcode;
  logic [AW-1:0] operand;
  logic          exec_valid;
  logic          pc_load;

  modport master (
    output rom_addr, rom_en, opcode, operand, exec_valid,
    input  rom_data, pc_load
  );

  modport slave (
    input  rom_addr, rom_en, opcode, operand, exec_valid,
    output rom_data, pc_load
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer: FETCH -> WAIT -> EXEC per instruction, sticky HALT.
// Optional feature macro: IFU_STALL_EN adds a stall input that holds the unit in FETCH.
module instr_fetch_unit #(
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef IFU_STALL_EN
  input  logic                 stall,
`endif
  instr_fetch_unit_if.master   bus,
  output logic [AW-1:0]        pc,
  output logic                 halted
);
  localparam int IW = AW + 5;
  localparam logic [4:0] HALT_OP = 5'b10111;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] pc_next;
  logic          stall_q;

`ifdef IFU_STALL_EN
  assign stall_q = stall;
`else
  assign stall_q = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      S_FETCH: if (!stall_q) state_next = S_WAIT;
      S_WAIT:  state_next = S_EXEC;
      S_EXEC: begin
        // Halt takes priority over a jump request in the same execute cycle.
        if (bus.opcode == HALT_OP) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
          pc_next    = bus.pc_load ? bus.operand : pc + AW'(1);
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= '0;
      bus.opcode  <= 5'b00000;
      bus.operand <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == S_WAIT) begin
        bus.opcode  <= bus.rom_data[IW-1:IW-5];
        bus.operand <= bus.rom_data[AW-1:0];
      end
    end
  end

  // rom_addr tracks the PC register directly; the read strobe is suppressed while reset is held.
  assign bus.rom_addr   = pc;
  assign bus.rom_en     = (state == S_FETCH) && !stall_q && !rst;
  assign bus.exec_valid = (state == S_EXEC);
  assign halted         = (state == S_HALT);
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and issue sequencer for the accumulator datapath. It holds the program counter and reads instruction words from a synchronous program ROM. Each word is split into a 5-bit opcode and an operand address, and the opcode is presented to the control unit for one execute cycle. The unit consumes the control unit's `pc_load` decision to redirect the program counter, and it owns the halt condition as a real register rather than a simulation stop.

## Interface
- `AW`, default 8: program address width; also the operand field width.
- `IW`, fixed at `AW+5`: instruction word width. Not overridable.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rom_addr`  out  AW: program ROM read address.
- `rom_en`  out  1: ROM read enable.
- `rom_data`  in  IW: ROM read data, valid the cycle after `rom_en`. Bits [IW-1:IW-5] are the opcode; bits [AW-1:0] are the operand.
- `opcode`  out  5: opcode to the control unit; held between updates.
- `operand`  out  AW: operand address; held between updates.
- `exec_valid`  out  1: high for exactly the execute cycle of each instruction.
- `pc_load`  in  1: jump request from the control unit; sampled only in EXEC.
- `pc`  out  AW: current program counter.
- `halted`  out  1: high once opcode `5'b10111` has been executed.
- `stall`  in  1: present only with `IFU_STALL_EN`.

## Operation
- FSM states: FETCH, WAIT, EXEC, HALT. The state after reset is FETCH.
- FETCH:
  - `rom_en`=1 and `rom_addr`=`pc`.
  - Next state is WAIT.
- WAIT:
  - `rom_en`=0.
  - Latch `rom_data` into `opcode` and `operand`.
  - Next state is EXEC.
- EXEC:
  - `exec_valid`=1.
  - If `opcode`=`5'b10111`, go to HALT. `pc` is unchanged and `pc_load` is ignored; halt wins over a jump.
  - Otherwise, if `pc_load`=1, then `pc`←`operand`. Else `pc`←`pc+1`, modulo 2^AW, so `pc` wraps from 2^AW−1 to 0.
  - Next state is FETCH.
- HALT:
  - `halted`=1 and `exec_valid`=0.
  - No ROM reads.
  - `pc`, `opcode` and `operand` are frozen.
  - Only `rst` leaves HALT.
- `pc_load` outside EXEC has no effect.
- Reset values: `pc`=0, `rom_addr`=0, `rom_en`=0, `opcode`=`5'b00000`, `operand`=0, `exec_valid`=0, `halted`=0. The state is FETCH.
- Reset asserted in any state, including mid-fetch or HALT, takes effect at the next edge. It overrides every other update in that cycle.
- Undefined opcodes (`5'b11000`–`5'b11111`) are treated as non-halt. The PC advances by `pc_load` or +1 as usual.

## Timing
- Three cycles per instruction:
  - cycle 0 is FETCH;
  - cycle 1 is WAIT, and `opcode` updates at the end of this cycle;
  - cycle 2 is EXEC.
- The first `exec_valid` after reset release occurs in the third cycle.
- `opcode` is stable for the whole EXEC cycle. `pc_load` must be valid combinationally within EXEC, and is registered at the end of EXEC.
- The new `pc` is visible on `rom_addr` in the immediately following FETCH cycle. There is no branch penalty beyond the normal three cycles.
- `halted` rises in the cycle after the halt instruction's EXEC cycle.
- `rom_addr` is registered and equals `pc` throughout.

## Configuration
- Macro: `IFU_STALL_EN`.
- Defined:
  - The `stall` input port exists.
  - While `stall`=1 in FETCH, the FSM stays in FETCH with `rom_en`=0 and all registers held.
  - The read is issued in the first FETCH cycle with `stall`=0.
  - `stall` is ignored in WAIT, EXEC and HALT.
- Undefined: no `stall` port, and FETCH always advances to WAIT after one cycle.

## Test plan
- ROM[0]=`{5'b00001,8'h00}`, ROM[1]=`{5'b01101,8'h00}`, `pc_load` tied 0 → `exec_valid` pulses at cycles 3 and 6 after reset release, with `opcode`=`00001` then `01101`; `pc` reaches 2.
- ROM[3]=`{5'b10100,8'h40}`, `pc_load`=1 in that EXEC → the next `rom_addr`=`8'h40`, and `pc` does not pass through 4.
- ROM[8'hFF] holds a non-jump instruction → after its EXEC, `pc`=`8'h00` and the next fetch reads ROM[0].
- ROM[5]=`{5'b10111,8'h22}` with `pc_load`=1 forced during EXEC → `halted`=1, `pc` stays 5, no further `rom_en`. Asserting `rst` for one cycle then returns all outputs to their reset values.
- `rst` asserted during WAIT → next cycle is FETCH, `pc`=0, `opcode`=`00000`, `exec_valid`=0.
- With `IFU_STALL_EN`, hold `stall`=1 for 4 cycles at FETCH of `pc`=2 → `rom_en` stays 0 for 4 cycles, then one read of address 2; instruction latency is 7 cycles.
